ex_muldiv: RTL

Iterative RV32M multiply/divide unit in the execute stage. It sits directly downstream of the execute operand selection and consumes the same selected ALU operands A and B. For every M-extension op it produces a 32-bit result after a multi-cycle computation. While the unit is busy, the pipeline control logic holds the execute stage.

---
 rtl/ex_muldiv.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the execute stage.
//
// The unit takes the operands already selected for the ALU. Every M-extension
// op finishes after a multi-cycle computation. The pipeline holds the execute
// stage while busy=1.
//
// Ports
//   clk     in   1   core clock, rising edge
//   rst     in   1   asynchronous, active-high reset
//   start   in   1   request; sampled only while busy=0
//   op      in   3   funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   opa     in  32   rs1: multiplicand or dividend
//   opb     in  32   rs2: multiplier or divisor
//   flush   in   1   abort the in-flight op (wins over start)
//   busy    out  1   op in flight
//   done    out  1   one-cycle pulse; result is valid in that cycle
//   result  out 32   registered result; holds its value until the next completion
//
// Handshake: start acts as "valid" and ~busy acts as "ready". A request
// transfers at a rising edge where start=1, busy=0 and flush=0. Because busy is
// already low in the done cycle, a new op can be accepted back-to-back.
//
// Configuration: define EX_MULDIV_FAST_MUL_EN to resolve all multiplies with a
// single-cycle 33x33 signed multiply captured on accept. Those ops then go
// straight to FIN. Divide timing is the same in both builds.
//
// Debug: the FSM state is visible as the enum signal `state`.

module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        res_neg;
  logic [63:0] acc;     // multiply: {partial product, multiplier}; divide: {remainder, quotient}
  logic [4:0]  count;

  // ---------------------------------------------------------------------------
  // Operand conditioning for the accept cycle
  // ---------------------------------------------------------------------------
  logic        a_signed_in;
  logic        b_signed_in;
  logic        a_neg_in;
  logic        b_neg_in;
  logic [31:0] a_abs_in;
  logic [31:0] b_abs_in;
  logic        res_neg_in;
  logic        special_in;
  logic        fast_mul_in;
  logic [63:0] acc_init;

`ifdef EX_MULDIV_FAST_MUL_EN
  logic signed [63:0] fast_a;
  logic signed [63:0] fast_b;
  logic        [63:0] fast_prod;
`endif

  always_comb begin
    // MULH, MULHSU, DIV and REM treat opa as signed; only MULH, DIV and REM treat opb as signed.
    a_signed_in = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed_in = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg_in    = a_signed_in & opa[31];
    b_neg_in    = b_signed_in & opb[31];
    a_abs_in    = a_neg_in ? (~opa + 32'd1) : opa;
    b_abs_in    = b_neg_in ? (~opb + 32'd1) : opb;
    // The remainder follows the dividend. The product and quotient follow the sign XOR.
    res_neg_in  = (op[2] && op[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
    // A zero divisor, or signed -2^31 / -1, is resolved directly in FIN.
    special_in  = op[2] && ((opb == 32'd0) ||
                  (!op[0] && (opa == 32'h8000_0000) && (opb == 32'hFFFF_FFFF)));
    // The multiplier goes into the low half for shift-add. The dividend goes there for restoring division.
    acc_init    = op[2] ? {32'd0, a_abs_in} : {32'd0, b_abs_in};
`ifdef EX_MULDIV_FAST_MUL_EN
    fast_mul_in = !op[2];
    fast_a      = 64'($signed({a_signed_in & opa[31], opa}));
    fast_b      = 64'($signed({b_signed_in & opb[31], opb}));
    fast_prod   = fast_a * fast_b;
    if (fast_mul_in) begin
      // The product is already signed, so FIN must not negate it again.
      acc_init   = fast_prod;
      res_neg_in = 1'b0;
    end
`else
    fast_mul_in = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------------
  // One radix-2 iteration
  // ---------------------------------------------------------------------------
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [31:0] div_sub;
  logic        div_ge;
  logic [63:0] div_next;

  always_comb begin
    // Shift-add: add the multiplicand when the multiplier LSB is set, then shift right together with the carry.
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_abs} : 33'd0);
    mul_next  = {mul_sum, acc[31:1]};
    // Restoring: move the next dividend bit into the remainder, then subtract if the divisor fits.
    div_shift = {acc[63:32], acc[31]};
    div_ge    = (div_shift >= {1'b0, b_abs});
    // When div_ge=1 the difference is below the divisor, so 32 bits are enough.
    div_sub   = div_shift[31:0] - b_abs;
    div_next  = div_ge ? {div_sub, acc[30:0], 1'b1}
                       : {div_shift[31:0], acc[30:0], 1'b0};
  end

  // ---------------------------------------------------------------------------
  // Final result selection, applied in FIN
  // ---------------------------------------------------------------------------
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] fin_result;

  always_comb begin
    prod = res_neg ? (~acc + 64'd1) : acc;
    quo  = res_neg ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem  = res_neg ? (~acc[63:32] + 32'd1) : acc[63:32];
    if (!op_q[2]) begin
      fin_result = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    end else if (opb_q == 32'd0) begin
      fin_result = op_q[1] ? opa_q : 32'hFFFF_FFFF;
    end else if (!op_q[0] && (opa_q == 32'h8000_0000) && (opb_q == 32'hFFFF_FFFF)) begin
      fin_result = op_q[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      fin_result = op_q[1] ? rem : quo;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 32'd0;
      count   <= 5'd0;
      op_q    <= 3'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      a_abs   <= 32'd0;
      b_abs   <= 32'd0;
      res_neg <= 1'b0;
      acc     <= 64'd0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        // Drop the op silently. The previous result stays visible.
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              op_q    <= op;
              opa_q   <= opa;
              opb_q   <= opb;
              a_abs   <= a_abs_in;
              b_abs   <= b_abs_in;
              res_neg <= res_neg_in;
              acc     <= acc_init;
              busy    <= 1'b1;
              if (special_in || fast_mul_in) begin
                state <= S_FIN;
              end else begin
                state <= S_CALC;
                count <= 5'd31;
              end
            end
          end
          S_CALC: begin
            acc <= op_q[2] ? div_next : mul_next;
            if (count == 5'd0) begin
              state <= S_FIN;
            end else begin
              count <= count - 5'd1;
            end
          end
          S_FIN: begin
            result <= fin_result;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
